// File: rtl/spi_frame_engine.sv
// spi_frame_engine: decodes an SPI frame ({addr, rw} byte, then one data byte) into memory write/read traffic.
// Optional macro SPI_FRAME_BURST_EN: while cs_n stays low, keep streaming bytes at incrementing addresses.
module spi_frame_engine #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs_n,
    input  logic                 mosi,
    input  logic                 sclk_pos,
    input  logic                 sclk_neg,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic [ADDR_BITS-1:0] addr,
    output logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_en,
    output logic                 rd_req,
    output logic                 miso,
    output logic                 miso_oe
);

    localparam int CNT_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        RD_WAIT  = 3'd2,
        RD_LOAD  = 3'd3,
        RD_SHIFT = 3'd4,
        WR       = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, shift_in;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [ADDR_BITS-1:0] addr_n;
    logic [DATA_BITS-1:0] wr_data_n;
    logic                 wr_en_n;
    logic                 rd_req_n;
    logic                 miso_oe_n;
`ifdef SPI_FRAME_BURST_EN
    logic                 rw, rw_n;
`endif

    // MSB-first receive: the new bit enters at the LSB.
    assign shift_in = {shreg[DATA_BITS-2:0], mosi};
    assign miso     = shreg[DATA_BITS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            addr    <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
            rd_req  <= 1'b0;
            miso_oe <= 1'b0;
`ifdef SPI_FRAME_BURST_EN
            rw      <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            addr    <= addr_n;
            wr_data <= wr_data_n;
            wr_en   <= wr_en_n;
            rd_req  <= rd_req_n;
            miso_oe <= miso_oe_n;
`ifdef SPI_FRAME_BURST_EN
            rw      <= rw_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        addr_n    = addr;
        wr_data_n = wr_data;
        wr_en_n   = 1'b0;
        rd_req_n  = 1'b0;
        miso_oe_n = miso_oe;
`ifdef SPI_FRAME_BURST_EN
        rw_n      = rw;
`endif
        if (cs_n) begin
            // Deselect aborts any frame; a partial write byte is simply dropped.
            state_n   = IDLE;
            bit_cnt_n = '0;
            miso_oe_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n   = ADDR;
                    bit_cnt_n = '0;
                end
                ADDR: begin
                    if (sclk_pos) begin
                        shreg_n   = shift_in;
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            addr_n = shift_in[DATA_BITS-1 -: ADDR_BITS];
`ifdef SPI_FRAME_BURST_EN
                            rw_n   = mosi;
`endif
                            if (mosi) begin
                                state_n  = RD_WAIT;
                                rd_req_n = 1'b1;
                            end else begin
                                state_n   = WR;
                                bit_cnt_n = '0;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    state_n = RD_LOAD;
                end
                RD_LOAD: begin
                    // Memory answers exactly one clk after rd_req, so the data is present now.
                    shreg_n   = rd_data;
                    miso_oe_n = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = RD_SHIFT;
                end
                RD_SHIFT: begin
                    if (sclk_neg && !sclk_pos) begin
                        shreg_n   = {shreg[DATA_BITS-2:0], 1'b0};
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state_n = DONE;
                        end
                    end
                end
                WR: begin
                    if (sclk_pos) begin
                        shreg_n   = shift_in;
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            wr_data_n = shift_in;
                            wr_en_n   = 1'b1;
                            state_n   = DONE;
                        end
                    end
                end
                DONE: begin
`ifdef SPI_FRAME_BURST_EN
                    // Next byte of the burst: address wraps naturally at 2^ADDR_BITS.
                    addr_n    = addr + ADDR_BITS'(1);
                    bit_cnt_n = '0;
                    if (rw) begin
                        rd_req_n = 1'b1;
                        state_n  = RD_WAIT;
                    end else begin
                        state_n  = WR;
                    end
`else
                    state_n = DONE;
`endif
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset) !(wr_en && rd_req));
    a_bit_cnt_bounded:   assert property (@(posedge clk) disable iff (reset) bit_cnt <= CNT_W'(DATA_BITS));

endmodule

// File: tb/tb_spi_frame_engine.sv
// Directed testbench for spi_frame_engine with a queue-based scoreboard and a free-running monitor.
module tb_spi_frame_engine;

    localparam int AB = 7;
    localparam int DB = 8;
    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs_n;
    logic          mosi;
    logic          sclk_pos;
    logic          sclk_neg;
    logic [DB-1:0] rd_data;
    logic [AB-1:0] addr;
    logic [DB-1:0] wr_data;
    logic          wr_en;
    logic          rd_req;
    logic          miso;
    logic          miso_oe;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected write: {cycle, addr, data}; expected read request: {cycle, addr}; expected MISO bits.
    logic [31+AB+DB:0] exp_wr_q[$];
    logic [31+AB:0]    exp_rd_q[$];
    logic [0:0]        exp_miso_q[$];

    spi_frame_engine #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .sclk_pos (sclk_pos),
        .sclk_neg (sclk_neg),
        .rd_data  (rd_data),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_req   (rd_req),
        .miso     (miso),
        .miso_oe  (miso_oe)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model: answers one clk after rd_req ----------------
    initial begin
        rd_data = '0;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                @(posedge clk);
                #1 rd_data = 8'hA5;
                @(posedge clk);
                #1 rd_data = 8'h00;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [31+AB+DB:0] ew;
        logic [31+AB:0]    er;
        logic [0:0]        em;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wr_en && rd_req) check("wr_rd_same_clk", 64'(1), 64'(0));
                if (wr_en) begin
                    if (exp_wr_q.size() == 0) begin
                        check("wr_en_unexpected", 64'(wr_en), 64'(0));
                    end else begin
                        ew = exp_wr_q.pop_front();
                        check("wr_cycle", 64'(cyc), 64'(ew[31+AB+DB:AB+DB]));
                        check("wr_addr", 64'(addr), 64'(ew[AB+DB-1:DB]));
                        check("wr_data", 64'(wr_data), 64'(ew[DB-1:0]));
                    end
                end
                if (rd_req) begin
                    if (exp_rd_q.size() == 0) begin
                        check("rd_req_unexpected", 64'(rd_req), 64'(0));
                    end else begin
                        er = exp_rd_q.pop_front();
                        check("rd_cycle", 64'(cyc), 64'(er[31+AB:AB]));
                        check("rd_addr", 64'(addr), 64'(er[AB-1:0]));
                    end
                end
                if (miso_oe && sclk_neg && !sclk_pos) begin
                    if (exp_miso_q.size() == 0) begin
                        check("miso_extra_shift", 64'(1), 64'(0));
                    end else begin
                        em = exp_miso_q.pop_front();
                        check("miso_bit", 64'(miso), 64'(em));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            sclk_pos = 1'b0;
            sclk_neg = 1'b0;
        end
    endtask

    // One SCLK period: rising pulse, gap, falling pulse, gap. Pushes an expectation on the last bit.
    task automatic send_bit(input logic b, input logic both, input int kind,
                            input logic [AB-1:0] ea, input logic [DB-1:0] ed);
        tick();
        mosi     = b;
        sclk_pos = 1'b1;
        sclk_neg = both;
        if (kind == K_WR) exp_wr_q.push_back({32'(cyc + 1), ea, ed});
        if (kind == K_RD) exp_rd_q.push_back({32'(cyc + 1), ea});
        tick();
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        tick();
        sclk_neg = 1'b1;
        tick();
        sclk_neg = 1'b0;
    endtask

    task automatic send_byte(input logic [DB-1:0] v, input logic both, input int kind,
                             input logic [AB-1:0] ea, input logic [DB-1:0] ed);
        for (int i = DB - 1; i >= 0; i--) begin
            send_bit(v[i], both, (i == 0) ? kind : K_NONE, ea, ed);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_addr"},    64'(addr),    64'(0));
        check({tag, "_wr_data"}, 64'(wr_data), 64'(0));
        check({tag, "_wr_en"},   64'(wr_en),   64'(0));
        check({tag, "_rd_req"},  64'(rd_req),  64'(0));
        check({tag, "_miso"},    64'(miso),    64'(0));
        check({tag, "_miso_oe"}, 64'(miso_oe), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic exp_bits [DB];
        int   waited;
        exp_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        reset = 1'b1; cs_n = 1'b1; mosi = 1'b0; sclk_pos = 1'b0; sclk_neg = 1'b0;
        repeat (2) begin
            tick();
            cs_n     = 1'($urandom_range(0, 1));
            mosi     = 1'($urandom_range(0, 1));
            sclk_pos = 1'($urandom_range(0, 1));
            sclk_neg = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_quiet("reset");
        tick();
        reset = 1'b0; cs_n = 1'b1; mosi = 1'b0; sclk_pos = 1'b0; sclk_neg = 1'b0;
        tick();
        @(negedge clk);
        check_quiet("post_reset_idle");

        // Write 0xC3 to 0x2A.
        tick(); cs_n = 1'b0;
        send_byte(8'h54, 1'b0, K_NONE, '0, '0);
        send_byte(8'hC3, 1'b0, K_WR, 7'h2A, 8'hC3);
        tick(); cs_n = 1'b1;
        idle(3);

        // Read 0x2A; memory returns 0xA5.
        foreach (exp_bits[i]) exp_miso_q.push_back(exp_bits[i]);
        tick(); cs_n = 1'b0;
        send_byte(8'h55, 1'b0, K_RD, 7'h2A, '0);
        waited = 0;
        while (!miso_oe && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        check("rd_miso_oe_on", 64'(miso_oe), 64'(1));
        for (int i = 0; i < DB; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, K_NONE, '0, '0);
        @(negedge clk);
        check("rd_bits_consumed", 64'(exp_miso_q.size()), 64'(0));
        check("rd_miso_oe_hold", 64'(miso_oe), 64'(1));
        tick(); cs_n = 1'b1;
        @(negedge clk);
        check("rd_miso_oe_before_edge", 64'(miso_oe), 64'(1));
        @(negedge clk);
        check("rd_miso_oe_off", 64'(miso_oe), 64'(0));
        idle(3);

        // Abort after 5 data bits of a write to 0x10, then a clean write of 0x7E to 0x11.
        tick(); cs_n = 1'b0;
        send_byte(8'h20, 1'b0, K_NONE, '0, '0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, K_NONE, '0, '0);
        tick(); cs_n = 1'b1;
        idle(3);
        tick(); cs_n = 1'b0;
        send_byte(8'h22, 1'b0, K_NONE, '0, '0);
        send_byte(8'h7E, 1'b0, K_WR, 7'h11, 8'h7E);
        tick(); cs_n = 1'b1;
        idle(3);

`ifndef SPI_FRAME_BURST_EN
        // Address byte with coincident pos/neg pulses, then stray pulses in DONE.
        tick(); cs_n = 1'b0;
        send_byte(8'h66, 1'b1, K_NONE, '0, '0);
        send_byte(8'h5A, 1'b0, K_WR, 7'h33, 8'h5A);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), K_NONE, '0, '0);
        tick(); cs_n = 1'b1;
        idle(3);
`else
        // Burst write wrapping the address from 0x7F to 0x00.
        tick(); cs_n = 1'b0;
        send_byte(8'hFE, 1'b0, K_NONE, '0, '0);
        send_byte(8'h01, 1'b0, K_WR, 7'h7F, 8'h01);
        send_byte(8'h02, 1'b0, K_WR, 7'h00, 8'h02);
        tick(); cs_n = 1'b1;
        idle(3);
`endif

        idle(5);
        @(negedge clk);
        check("wr_queue_drained", 64'(exp_wr_q.size()), 64'(0));
        check("rd_queue_drained", 64'(exp_rd_q.size()), 64'(0));
        check("miso_queue_drained", 64'(exp_miso_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_frame_engine.md
Name: spi_frame_engine

Overview:
- Consumes the conditioned SPI signals produced by the input conditioners: chip select, MOSI, and the SCLK edge pulses.
- Decodes one SPI transaction into an address and a read/write bit, then either collects a write byte or serializes a read byte onto MISO.
- Sits between the conditioner stage and the synchronous data memory.

Parameters:
- ADDR_BITS, 7, address width; the first frame byte is {addr[ADDR_BITS-1:0], rw}.
- DATA_BITS, 8, data byte width; this is also the shift register width.

Ports:
- clk  in  1  system clock; all inputs are already synchronous to it.
- reset  in  1  synchronous, active-high reset.
- cs_n  in  1  conditioned chip select, active low.
- mosi  in  1  conditioned MOSI level.
- sclk_pos  in  1  one-clk pulse at the SCLK rising edge.
- sclk_neg  in  1  one-clk pulse at the SCLK falling edge.
- rd_data  in  DATA_BITS  memory read data; valid on the clk after rd_req.
- addr  out  ADDR_BITS  latched transaction address.
- wr_data  out  DATA_BITS  write byte; valid while wr_en=1.
- wr_en  out  1  one-clk memory write strobe.
- rd_req  out  1  one-clk memory read request.
- miso  out  1  serial read data, MSB first.
- miso_oe  out  1  MISO output enable for the external tristate.

Behaviour:
- Reset (sync, high): state=IDLE, shreg=0, bit_cnt=0. Outputs addr=0, wr_data=0, wr_en=0, rd_req=0, miso=0, miso_oe=0. Reset overrides every other input.
- FSM states: IDLE, ADDR, RD_WAIT, RD_LOAD, RD_SHIFT, WR, DONE.
- cs_n=1 in any state: next state is IDLE. bit_cnt clears and miso_oe drops on the same clk edge. This aborts a transaction mid-frame, and no wr_en is issued for a partial write byte.
- IDLE: cs_n=0 moves to ADDR with bit_cnt=0.
- ADDR: each sclk_pos shifts mosi into shreg LSB (left shift, MSB first) and increments bit_cnt. On the DATA_BITS-th sclk_pos:
  - addr <= upper ADDR_BITS of the completed byte; rw = last bit.
  - rw=1: go to RD_WAIT and pulse rd_req for exactly one clk.
  - rw=0: go to WR with bit_cnt=0.
- RD_WAIT: one clk, then RD_LOAD.
- RD_LOAD: shreg <= rd_data, miso_oe <= 1, bit_cnt=0, then RD_SHIFT. Memory read latency is fixed at 1 clk after rd_req.
- RD_SHIFT: miso = shreg MSB, combinational from shreg. Each sclk_neg shifts shreg left and increments bit_cnt. After the DATA_BITS-th sclk_neg go to DONE; miso_oe stays 1 until cs_n=1. sclk_pos pulses are ignored in this state.
- WR: each sclk_pos shifts mosi in, as in ADDR. On the DATA_BITS-th sclk_pos, wr_data <= completed byte, wr_en=1 for one clk, then DONE.
- DONE: all SCLK pulses are ignored; wait for cs_n=1 (see Optional Feature).
- sclk_pos and sclk_neg asserted in the same clk: sclk_pos is processed and sclk_neg is ignored.
- SCLK pulses in IDLE are ignored.
- rd_req and wr_en are never high in the same clk.
- bit_cnt is sized for DATA_BITS (clog2(DATA_BITS)+1 bits) and never wraps within a frame.

Optional Feature:
- Macro: SPI_FRAME_BURST_EN.
- Defined: DONE is not terminal while cs_n=0.
  - After a write byte: addr increments, modulo 2^ADDR_BITS (7F -> 00), and the FSM returns to WR for the next byte.
  - After a read byte: addr increments, modulo 2^ADDR_BITS, rd_req pulses, and the FSM returns to RD_WAIT, so successive bytes stream continuously.
  - The address update and the rd_req pulse occur on the same clk as the DONE decision.
- Undefined: DONE ignores all SCLK pulses until cs_n=1, giving one byte per transaction.

Test Plan:
- Reset=1 for 2 clk with random inputs -> all outputs 0, state IDLE; first clk after reset release with cs_n=1 -> still IDLE.
- Write: cs_n=0, shift 0x54 (addr 0x2A, rw=0) then 0xC3 on sclk_pos -> single wr_en pulse with addr=0x2A and wr_data=0xC3, one clk after the 16th sclk_pos; no rd_req.
- Read: shift 0x55 (addr 0x2A, rw=1); rd_req pulses once; drive rd_data=0xA5 the next clk -> miso_oe=1, and miso reads 1,0,1,0,0,1,0,1 sampled before each of 8 sclk_neg; cs_n=1 -> miso_oe=0 next clk.
- Abort: cs_n rises after 5 data bits of a write to addr 0x10 -> no wr_en, IDLE next clk; a following full write to 0x11 with data 0x7E completes correctly.
- Simultaneous sclk_pos and sclk_neg in ADDR, plus extra SCLK pulses in DONE -> only the posedge is counted; extra pulses cause no wr_en or rd_req (macro undefined).
- With SPI_FRAME_BURST_EN: write to addr 0x7F with data 0x01, 0x02 -> wr_en twice, at addr 0x7F then 0x00.
